psum_drain: RTL
===============

Name: psum_drain

Overview:
- Collects partial sums leaving the bottom PE row of the systolic array.
- In the array, column j's result emerges j cycles after column 0's, so this block de-skews the columns into one aligned vector per output row.
- Each aligned vector is buffered in a small FIFO and handed downstream with a valid/ready handshake, tagged with end-of-tile framing.
- The array cannot be stalled. Aligned vectors that arrive when the FIFO is full are dropped and flagged.

Parameters:
- data_width, 23, operand width; each column's sum is 2*data_width bits.
- w_tile_column_size, 3, number of PE columns (COLS).
- TILE_ROWS, 4, aligned vectors per tile; sets out_last framing.
- FIFO_DEPTH, 4, buffered aligned vectors; power of two, at least 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-high: asserted = reset, sampled on the clk rising edge.
- drain_clr  in  1  synchronous flush; same effect as reset except it does not clear ovf_flag.
- in_valid  in  1  qualifies column 0 of in_sum this cycle.
- in_sum  in  2*data_width*COLS  bottom-row out_sum; column j occupies bits [(j+1)*2*data_width-1 : j*2*data_width].
- out_data  out  2*data_width*COLS  aligned vector at the FIFO head; same column packing as in_sum.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts; a pop occurs when out_valid and out_ready are both high.
- out_last  out  1  head entry is row TILE_ROWS-1 of its tile.
- ovf_flag  out  1  sticky: at least one aligned vector was dropped.

Behaviour:
- Reset (rst_n=1 at an edge):
  - delay lines, valid shift register, FIFO pointers and count, row counter and ovf_flag go to 0.
  - Resulting outputs: out_valid=0, out_data=0, out_last=0, ovf_flag=0.
  - Reset mid-stream discards all in-flight data; no partial vector is emitted afterwards.
- De-skew:
  - Column j passes through a register delay of (COLS-1-j) stages; column COLS-1 has zero delay.
  - in_valid passes through a (COLS-1)-stage shift register to give aligned_valid.
  - If column 0 is sampled with in_valid=1 at edge k, column j is sampled at edge k+j.
  - The aligned vector is pushed at edge k+COLS-1; out_valid rises in the cycle after that edge.
  - A back-to-back in_valid stream yields one push per cycle.
- Row counter (0..TILE_ROWS-1):
  - Advances on every aligned_valid, whether the push is accepted or dropped, so tile framing survives drops.
  - Wraps from TILE_ROWS-1 to 0.
  - The entry's last bit is 1 when the counter equals TILE_ROWS-1.
- FIFO:
  - Registered storage; out_data/out_last show the head entry, and are 0 when empty.
  - Push when aligned_valid and (not full, or pop in the same cycle). Full with simultaneous pop: both occur and count is unchanged.
  - Empty: out_ready is ignored and no pointer moves.
  - Full with no pop: the vector is dropped, ovf_flag is set at that edge, and FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- drain_clr:
  - Clears delay lines, valid shift register, FIFO and row counter at the edge; ovf_flag is held.
  - If rst_n and drain_clr are both asserted, rst_n wins.
- Arithmetic: none. Data is passed bit-exact, with no sign handling or truncation.

Optional Feature:
- Macro: PSUM_DRAIN_OVF_CNT_EN.
- Defined:
  - Adds output port ovf_cnt, 8 bits.
  - ovf_cnt increments on every dropped vector and saturates at 255.
  - Cleared by rst_n only; drain_clr holds it.
  - ovf_flag still behaves as specified above.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Skew alignment (COLS=3, data_width=23):
  - Stimulus: in_valid=1 at cycle 0 only; column 0 = 46'h1 at cycle 0, column 1 = 46'h2 at cycle 1, column 2 = 46'h3 at cycle 2; out_ready=1.
  - Required: out_valid first high at cycle 3, with out_data = {46'h3,46'h2,46'h1}; out_last=0; exactly one pop.
- Tile framing:
  - Stimulus: 8 consecutive skewed vectors with out_ready=1.
  - Required: 8 pops in order; out_last=1 on the 4th and 8th only.
- Overflow and backpressure:
  - Stimulus: out_ready=0 while 6 vectors stream in (FIFO_DEPTH=4), then out_ready=1.
  - Required: exactly the first 4 vectors are popped, in order; ovf_flag rises at the 5th drop edge and stays 1; out_last framing still marks the 4th vector.
  - With PSUM_DRAIN_OVF_CNT_EN: ovf_cnt=2.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, out_ready=1, aligned vector arriving.
  - Required: count remains 4; no drop; ovf_flag unchanged.
- Reset and clear mid-stream:
  - Stimulus: assert rst_n for one cycle while columns are still in the delay lines.
  - Required: out_valid=0 afterwards; no vector emitted from pre-reset data; ovf_flag=0.
  - Repeat with drain_clr after an overflow: ovf_flag stays 1 and the FIFO is empty.

Source files
------------

// File: rtl/psum_drain.sv
// psum_drain - de-skews the bottom-row partial sums of the systolic array
// into one aligned vector per output row. Each vector is buffered in a small
// FIFO and handed downstream over a valid/ready handshake with end-of-tile
// framing. The array cannot be stalled, so vectors that arrive while the FIFO
// is full are dropped and flagged.
//
// Optional feature macro: PSUM_DRAIN_OVF_CNT_EN adds an 8-bit saturating
// drop counter on port ovf_cnt. It is cleared only by rst_n.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-high (despite the name)
//   drain_clr  synchronous flush of the datapath; ovf_flag is kept
//   in_valid   qualifies column 0 of in_sum this cycle
//   in_sum     bottom-row sums, column j in bits [(j+1)*2*dw-1 : j*2*dw]
//   out_data   aligned vector at the FIFO head (0 when empty)
//   out_valid  FIFO non-empty
//   out_ready  downstream accepts; pop on out_valid && out_ready
//   out_last   head entry is the last row of its tile
//   ovf_flag   sticky: at least one aligned vector was dropped
//   ovf_cnt    (optional) saturating count of dropped vectors
module psum_drain #(
  parameter int data_width         = 23,
  parameter int w_tile_column_size = 3,
  parameter int TILE_ROWS          = 4,
  parameter int FIFO_DEPTH         = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         drain_clr,
  input  logic                                         in_valid,
  input  logic [2*data_width*w_tile_column_size-1:0]   in_sum,
  output logic [2*data_width*w_tile_column_size-1:0]   out_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic                                         out_last,
  output logic                                         ovf_flag
`ifdef PSUM_DRAIN_OVF_CNT_EN
  ,
  output logic [7:0]                                   ovf_cnt
`endif
);

  localparam int COLS = w_tile_column_size;
  localparam int SW   = 2 * data_width;
  localparam int VW   = SW * COLS;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int RW   = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [RW-1:0] ROW_MAX = RW'(TILE_ROWS - 1);

  // Reset and drain_clr both flush the datapath; only reset touches ovf state.
  logic flush;
  assign flush = rst_n | drain_clr;

  logic [VW-1:0] aligned;
  logic          aligned_valid;

  // Column j is delayed by COLS-1-j stages so that all columns of one output
  // row line up with the last column, which passes straight through.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    if (j == COLS - 1) begin : g_direct
      assign aligned[j*SW +: SW] = in_sum[j*SW +: SW];
    end else begin : g_delay
      localparam int D = COLS - 1 - j;
      logic [SW-1:0] pipe_q [D];

      always_ff @(posedge clk) begin
        if (flush) begin
          for (int s = 0; s < D; s++) pipe_q[s] <= '0;
        end else begin
          pipe_q[0] <= in_sum[j*SW +: SW];
          for (int s = 1; s < D; s++) pipe_q[s] <= pipe_q[s-1];
        end
      end

      assign aligned[j*SW +: SW] = pipe_q[D-1];
    end
  end

  // in_valid travels alongside column 0, so it becomes aligned_valid exactly
  // when the full row is presented on the aligned bus.
  if (COLS == 1) begin : g_vld_direct
    assign aligned_valid = in_valid;
  end else begin : g_vld_delay
    logic [COLS-2:0] vld_q;

    always_ff @(posedge clk) begin
      if (flush) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= in_valid;
        for (int s = 1; s < COLS - 1; s++) vld_q[s] <= vld_q[s-1];
      end
    end

    assign aligned_valid = vld_q[COLS-2];
  end

  logic [VW:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [RW-1:0] row_q;
  logic          ovf_flag_q;
  logic          empty, full, pop, push, drop, row_last;
  logic [VW:0]   head;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign pop      = !empty && out_ready;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign push     = aligned_valid && (!full || pop);
  assign drop     = aligned_valid && full && !pop;
  assign row_last = (row_q == ROW_MAX);

  // Pointers, occupancy and tile row position. The row counter advances on
  // dropped vectors too, so tile framing stays correct after an overflow.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      row_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
      if (aligned_valid) begin
        if (row_last) row_q <= '0;
        else          row_q <= row_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {row_last, aligned};
  end

  // Sticky overflow flag; drain_clr leaves it alone.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ovf_flag_q <= 1'b0;
    end else if (!drain_clr && drop) begin
      ovf_flag_q <= 1'b1;
    end
  end

`ifdef PSUM_DRAIN_OVF_CNT_EN
  logic [7:0] ovf_cnt_q;

  // Saturating drop counter, held across drain_clr.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ovf_cnt_q <= '0;
    end else if (!drain_clr && drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

  assign head      = mem_q[rd_ptr_q];
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : head[VW-1:0];
  assign out_last  = !empty && head[VW];
  assign ovf_flag  = ovf_flag_q;

endmodule
